// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// EXE-stage sequencer for MIPS loads and stores against a single-port,
// word-wide, big-endian data memory with a req/ack handshake.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid, i_instr_op   EXE instruction valid and its opcode field
//   i_addr, i_store_data  effective byte address and rt value for stores
//   o_stall               freeze the pipeline while an access is pending
//   o_mem_*               memory request bus (word address, byte enables,
//                         lane-replicated store data), held until ack
//   i_mem_ack, i_mem_rdata  memory completion and read word
//   o_done                1-cycle pulse when an access finishes
//   o_load_op, o_addr_lo, o_load_data  inputs to the load-alignment unit
//   o_addr_err            1-cycle pulse: misaligned access, no bus cycle
//   o_bus_err             1-cycle pulse: access abandoned on timeout
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic [5:0]  o_load_op,
  output logic [1:0]  o_addr_lo,
  output logic [31:0] o_load_data,
  output logic        o_addr_err,
  output logic        o_bus_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [5:0]        load_op_q, load_op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;

  logic        is_load, is_store, misalign;
  logic [1:0]  a;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  assign a = i_addr[1:0];

  // Opcode decode, alignment check and big-endian lane placement.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = i_store_data;
    case (i_instr_op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: is_load = 1'b1;
      OP_SB: begin
        is_store = 1'b1;
        be_c     = 4'b1000 >> a;
        wdata_c  = {4{i_store_data[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        be_c     = a[1] ? 4'b0011 : 4'b1100;
        wdata_c  = {2{i_store_data[15:0]}};
      end
      OP_SW: is_store = 1'b1;
      OP_SWL: begin
        is_store = 1'b1;
        be_c     = 4'b1111 >> a;
        wdata_c  = i_store_data >> {a, 3'b000};
      end
      OP_SWR: begin
        // Shifting left by 3-a keeps the low (3-a) lanes cleared.
        is_store = 1'b1;
        be_c     = 4'b1111 << (2'd3 - a);
        wdata_c  = i_store_data << {2'd3 - a, 3'b000};
      end
      default: ;
    endcase
    misalign = (((i_instr_op == OP_LW) || (i_instr_op == OP_SW)) && (a != 2'b00)) ||
               (((i_instr_op == OP_LH) || (i_instr_op == OP_LHU) ||
                 (i_instr_op == OP_SH)) && a[0]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_op_d   = load_op_q;
    addr_lo_d   = addr_lo_q;
    load_data_d = load_data_q;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    o_stall     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid && (is_load || is_store)) begin
          if (misalign) begin
            addr_err_d = 1'b1;
          end else begin
            o_stall     = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {i_addr[31:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            load_op_d   = i_instr_op;
            addr_lo_d   = a;
            cnt_d       = '0;
            state_d     = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        o_stall = 1'b1;
        // Ack is checked first so it wins over a coincident timeout.
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) load_data_d = i_mem_rdata;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The instruction seen in DONE is the next one; it is evaluated in IDLE.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      load_op_q   <= '0;
      addr_lo_q   <= '0;
      load_data_q <= '0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_op_q   <= load_op_d;
      addr_lo_q   <= addr_lo_d;
      load_data_q <= load_data_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_done      = (state_q == S_DONE);
  assign o_load_op   = load_op_q;
  assign o_addr_lo   = addr_lo_q;
  assign o_load_data = load_data_q;
  assign o_addr_err  = addr_err_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [5:0]  i_instr_op;
  logic [31:0] i_addr, i_store_data;
  logic        o_stall, o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_done;
  logic [5:0]  o_load_op;
  logic [1:0]  o_addr_lo;
  logic [31:0] o_load_data;
  logic        o_addr_err, o_bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_ld = '0;

  typedef struct {
    logic [5:0]  op;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic [1:0]  lo;
    bit          tmo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_instr_op(i_instr_op),
    .i_addr(i_addr), .i_store_data(i_store_data), .o_stall(o_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_done(o_done), .o_load_op(o_load_op),
    .o_addr_lo(o_addr_lo), .o_load_data(o_load_data), .o_addr_err(o_addr_err),
    .o_bus_err(o_bus_err)
  );

  // One access: push the expectation, then watch the bus cycle by cycle.
  // ack_at = BUSY cycle (1-based) carrying the ack; 0 = never acknowledged.
  task automatic run_access(input string name, input logic [5:0] op,
                            input logic [31:0] addr, input logic [31:0] rt,
                            input logic we, input int ack_at,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input int exp_stall,
                            input int exp_req);
    exp_t e;
    logic [31:0] m;
    int stall_n = 0, req_n = 0, done_n = 0, berr_n = 0, done_k = -1, end_k = -1;
    e.op = op; e.we = we; e.maddr = {addr[31:2], 2'b00}; e.be = exp_be;
    e.wdata = exp_wdata; e.lo = addr[1:0]; e.tmo = (ack_at == 0);
    e.ldata = (!we && ack_at > 0) ? rdata : last_ld;
    sb.push_back(e);
    m = '0;
    for (int b = 0; b < 4; b++) if (exp_be[b]) m[8*b +: 8] = 8'hFF;

    @(posedge clk); #1;
    i_valid = 1'b1; i_instr_op = op; i_addr = addr; i_store_data = rt;
    #1;
    stall_n += int'(o_stall);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
      i_mem_rdata = 32'h0BAD_F00D;
      if (o_done || o_bus_err) i_valid = 1'b0;
      #1;
      stall_n += int'(o_stall);
      req_n   += int'(o_mem_req);
      if (o_mem_req && sb.size() > 0) begin
        n_tests++;
        if ({o_mem_we, o_mem_addr, o_mem_be} !== {sb[0].we, sb[0].maddr, sb[0].be}) begin
          n_fail++;
          $display("FAIL %s bus k=%0d: we/addr/be %b/%h/%b, required %b/%h/%b", name, k,
                   o_mem_we, o_mem_addr, o_mem_be, sb[0].we, sb[0].maddr, sb[0].be);
        end
        if (we) begin
          n_tests++;
          if ((o_mem_wdata & m) !== (sb[0].wdata & m)) begin
            n_fail++;
            $display("FAIL %s wdata k=%0d: %h, required %h (mask %h)", name, k,
                     o_mem_wdata, sb[0].wdata, m);
          end
        end
      end
      if (o_done) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k;
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s done with empty scoreboard", name);
          end else begin
            e = sb.pop_front();
            n_tests++;
            if ({o_load_op, o_addr_lo, o_load_data} !== {e.op, e.lo, e.ldata}) begin
              n_fail++;
              $display("FAIL %s done: op/lo/data %h/%b/%h, required %h/%b/%h", name,
                       o_load_op, o_addr_lo, o_load_data, e.op, e.lo, e.ldata);
            end
            last_ld = e.ldata;
            n_tests++;
            if (done_k != ack_at + 1) begin
              n_fail++;
              $display("FAIL %s done cycle: %0d, required %0d", name, done_k, ack_at + 1);
            end
          end
        end
      end
      if (o_bus_err) begin
        berr_n++;
        if (end_k < 0 && sb.size() > 0) begin
          e = sb.pop_front();
          n_tests++;
          if (o_load_data !== last_ld) begin
            n_fail++;
            $display("FAIL %s load_data after timeout: %h, required %h", name, o_load_data, last_ld);
          end
        end
      end
      if (o_mem_req && k == ack_at) begin
        i_mem_ack = 1'b1;
        i_mem_rdata = rdata;
      end
      if (end_k < 0 && (o_done || o_bus_err)) end_k = k;
      if (end_k >= 0 && k == end_k + 2) break;
    end
    i_valid = 1'b0;
    i_mem_ack = 1'b0;
    if (end_k < 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s no done/bus_err within 60 cycles", name);
      sb.delete();
    end
    n_tests++;
    if (stall_n != exp_stall) begin
      n_fail++;
      $display("FAIL %s stall cycles: %0d, required %0d", name, stall_n, exp_stall);
    end
    n_tests++;
    if (req_n != exp_req) begin
      n_fail++;
      $display("FAIL %s req cycles: %0d, required %0d", name, req_n, exp_req);
    end
    n_tests++;
    if (done_n != (e.tmo ? 0 : 1) || berr_n != (e.tmo ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s pulses: done %0d bus_err %0d, required %0d/%0d", name,
               done_n, berr_n, e.tmo ? 0 : 1, e.tmo ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; i_instr_op = '0; i_addr = '0;
    i_store_data = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_done,
         o_load_op, o_addr_lo, o_load_data, o_addr_err, o_bus_err} !== 114'd0) begin
      n_fail++;
      $display("FAIL reset outputs: req %b be %b addr %h ld %h done %b, required all 0",
               o_mem_req, o_mem_be, o_mem_addr, o_load_data, o_done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({o_stall, o_mem_req, o_done, o_addr_err, o_bus_err} !== 5'd0) begin
      n_fail++;
      $display("FAIL after release: stall/req/done/aerr/berr %b%b%b%b%b, required 00000",
               o_stall, o_mem_req, o_done, o_addr_err, o_bus_err);
    end
  endtask

  task automatic test_misalign(input string name, input logic [5:0] op, input logic [31:0] addr);
    @(posedge clk); #1;
    i_valid = 1'b1; i_instr_op = op; i_addr = addr; i_store_data = 32'h55AA55AA;
    #1;
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++; $display("FAIL %s stall: %b, required 0", name, o_stall);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({o_addr_err, o_mem_req} !== 2'b10) begin
      n_fail++; $display("FAIL %s pulse: addr_err/req %b%b, required 10", name, o_addr_err, o_mem_req);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({o_addr_err, o_mem_req, o_stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s after: addr_err/req/stall %b%b%b, required 000", name,
               o_addr_err, o_mem_req, o_stall);
    end
  endtask

  task automatic test_non_mem;
    @(posedge clk); #1;
    i_valid = 1'b1; i_instr_op = 6'h08; i_addr = 32'h00000003;
    #1;
    n_tests++;
    if (o_stall !== 1'b0) begin
      n_fail++; $display("FAIL non_mem stall: %b, required 0", o_stall);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({o_mem_req, o_addr_err, o_done, o_bus_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL non_mem outputs: req/aerr/done/berr %b%b%b%b, required 0000",
               o_mem_req, o_addr_err, o_done, o_bus_err);
    end
    i_valid = 1'b0;
  endtask

  // SW, then an LBU already waiting in EXE during the DONE cycle.
  task automatic test_back_to_back;
    @(posedge clk); #1;
    i_valid = 1'b1; i_instr_op = OP_SW; i_addr = 32'h00003000; i_store_data = 32'h01020304;
    @(posedge clk); #1;
    i_mem_ack = 1'b1;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    i_instr_op = OP_LBU; i_addr = 32'h00003001;
    #1;
    n_tests++;
    if ({o_done, o_stall} !== 2'b10) begin
      n_fail++; $display("FAIL b2b done cycle: done/stall %b%b, required 10", o_done, o_stall);
    end
    @(posedge clk); #2;
    n_tests++;
    if ({o_stall, o_mem_req, o_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b idle cycle: stall/req/done %b%b%b, required 100", o_stall, o_mem_req, o_done);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be} !== {1'b1, 1'b0, 32'h00003000, 4'b1111}) begin
      n_fail++;
      $display("FAIL b2b load bus: req/we/addr/be %b/%b/%h/%b, required 1/0/00003000/1111",
               o_mem_req, o_mem_we, o_mem_addr, o_mem_be);
    end
    i_mem_ack = 1'b1; i_mem_rdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    i_mem_ack = 1'b0; i_valid = 1'b0; i_mem_rdata = '0;
    n_tests++;
    if ({o_done, o_load_op, o_addr_lo, o_load_data} !== {1'b1, OP_LBU, 2'b01, 32'hA1B2C3D4}) begin
      n_fail++;
      $display("FAIL b2b load done: done/op/lo/data %b/%h/%b/%h, required 1/%h/01/a1b2c3d4",
               o_done, o_load_op, o_addr_lo, o_load_data, OP_LBU);
    end
    last_ld = 32'hA1B2C3D4;
  endtask

  task automatic test_reset_mid_busy;
    @(posedge clk); #1;
    i_valid = 1'b1; i_instr_op = OP_LW; i_addr = 32'h00006000;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({o_mem_req, o_stall} !== 2'b11) begin
      n_fail++; $display("FAIL mid_busy pre-reset req/stall: %b%b, required 11", o_mem_req, o_stall);
    end
    rst_n = 1'b0; i_valid = 1'b0;
    #1;
    n_tests++;
    if ({o_mem_req, o_stall} !== 2'b00) begin
      n_fail++; $display("FAIL mid_busy async drop req/stall: %b%b, required 00", o_mem_req, o_stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_done,
         o_load_op, o_addr_lo, o_load_data, o_addr_err, o_bus_err} !== 114'd0) begin
      n_fail++;
      $display("FAIL mid_busy outputs after reset: req %b be %b addr %h ld %h, required all 0",
               o_mem_req, o_mem_be, o_mem_addr, o_load_data);
    end
    last_ld = '0;
    run_access("post_reset_sw", OP_SW, 32'h00006004, 32'h76543210, 1'b1, 1, '0,
               4'b1111, 32'h76543210, 2, 1);
  endtask

  initial begin
    test_reset;
    run_access("sb", OP_SB, 32'h00001003, 32'h000000AB, 1'b1, 1, '0,
               4'b0001, 32'hABABABAB, 2, 1);
    run_access("lw", OP_LW, 32'h00002000, 32'h0, 1'b0, 3, 32'hDEADBEEF,
               4'b1111, 32'h0, 4, 3);
    test_misalign("lh_odd", OP_LH, 32'h00002001);
    test_misalign("sw_2", OP_SW, 32'h00002002);
    test_misalign("lhu_3", OP_LHU, 32'h00002003);
    test_misalign("lw_1", OP_LW, 32'h00002001);
    run_access("swl", OP_SWL, 32'h00004002, 32'h11223344, 1'b1, 1, '0,
               4'b0011, 32'h00001122, 2, 1);
    run_access("swr", OP_SWR, 32'h00004001, 32'h11223344, 1'b1, 2, '0,
               4'b1100, 32'h33440000, 3, 2);
    run_access("sh_hi", OP_SH, 32'h00004002, 32'h0000BEEF, 1'b1, 1, '0,
               4'b0011, 32'hBEEFBEEF, 2, 1);
    run_access("sb_0", OP_SB, 32'h00004000, 32'h00000077, 1'b1, 1, '0,
               4'b1000, 32'h77777777, 2, 1);
    run_access("lw_timeout", OP_LW, 32'h00005000, 32'h0, 1'b0, 0, '0,
               4'b1111, 32'h0, 9, 8);
    run_access("sw_after_to", OP_SW, 32'h00005004, 32'hCAFEF00D, 1'b1, 2, '0,
               4'b1111, 32'hCAFEF00D, 3, 2);
    run_access("lw_ack_at_last", OP_LW, 32'h00005008, 32'h0, 1'b0, 8, 32'h13579BDF,
               4'b1111, 32'h0, 9, 8);
    test_non_mem;
    test_back_to_back;
    test_reset_mid_busy;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
EXE-stage sequencer for all MIPS load/store instructions against a single-port, word-wide, big-endian data memory with a req/ack handshake.
- Checks alignment, generates the word address, byte enables and lane-replicated store data.
- Holds the pipeline stall while a transaction is outstanding and times out hung accesses.
- For loads, presents the captured memory word plus the latched opcode and address low bits to the downstream load-alignment unit.

Parameters:
TIMEOUT_CYCLES, 16, number of BUSY cycles without i_mem_ack before the access is abandoned with o_bus_err.
CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
i_clk  in  1  clock; all state changes on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_valid  in  1  EXE holds an instruction this cycle.
i_instr_op  in  6  opcode field; the `OP_* macros from OP.v.
i_addr  in  32  effective byte address.
i_store_data  in  32  rt value for stores.
o_stall  out  1  freeze the pipeline.
o_mem_req  out  1  memory request; held until ack.
o_mem_we  out  1  1 = store.
o_mem_addr  out  32  word address {addr[31:2],2'b00}.
o_mem_be  out  4  byte enables; be[3] = bits 31:24 = byte offset 00.
o_mem_wdata  out  32  lane-positioned store data.
i_mem_ack  in  1  access complete this cycle; rdata valid for loads.
i_mem_rdata  in  32  read word.
o_done  out  1  1-cycle pulse: access finished.
o_load_op  out  6  latched opcode for the load-alignment unit.
o_addr_lo  out  2  latched i_addr[1:0].
o_load_data  out  32  captured i_mem_rdata.
o_addr_err  out  1  1-cycle pulse: misaligned access, no bus cycle.
o_bus_err  out  1  1-cycle pulse: timeout.

Behaviour:
Reset (async, i_rst_n=0):
- State IDLE.
- All registered outputs 0; o_mem_be 4'b0000; timeout counter 0.
- o_mem_req drops immediately, even mid-transaction.

Memory ops: LB LH LWL LW LBU LHU LWR SB SH SWL SW SWR. Any other opcode with i_valid=1 is ignored: no stall, no pulse.

Misalignment:
- Condition: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
- In IDLE: o_addr_err pulses in the next cycle, no request, no stall, state stays IDLE.

FSM IDLE -> BUSY -> DONE -> IDLE:
- IDLE:
  - Combinational o_stall = i_valid & legal mem op & aligned.
  - On that edge: latch op, address, be, wdata; set o_mem_req=1; clear the counter; go to BUSY.
- BUSY:
  - o_stall=1; o_mem_req, o_mem_addr, o_mem_be, o_mem_we and o_mem_wdata held stable.
  - On an edge with i_mem_ack=1: capture i_mem_rdata into o_load_data (loads only; stores leave it unchanged), drop o_mem_req, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack: drop o_mem_req, pulse o_bus_err, go to IDLE. o_load_data is not updated.
  - Ack on the same edge as timeout: ack wins.
- DONE:
  - o_stall=0; o_done=1 for exactly 1 cycle; o_load_op, o_addr_lo and o_load_data are valid.
  - Next edge returns to IDLE.
  - The instruction now in EXE is new and is evaluated in IDLE on the following cycle. Back-to-back accesses therefore cost 1 idle cycle.

Minimum latency with ack in the first BUSY cycle: stall for 2 cycles (accept cycle + BUSY), done in the 3rd.

Byte enables / data, big-endian (a = addr[1:0], rt = i_store_data):
- Loads: be=1111.
- SB: be = 1000>>a; wdata = {4{rt[7:0]}}.
- SH: a[1]=0 -> 1100, else 0011; wdata = {2{rt[15:0]}}.
- SW: be=1111, wdata=rt.
- SWL: be = 1111>>a; wdata = rt>>(8*a).
- SWR: be = 1111<<(3-a) truncated to 4 bits (00:1000, 01:1100, 10:1110, 11:1111); wdata = rt<<(8*(3-a)).
- Disabled lanes of wdata: don't care.

Test Plan:
- SB addr 0x00001003, rt 0x000000AB, ack in 1st BUSY cycle -> o_mem_addr 0x00001000, be 0001, we 1, wdata 0xABABABAB; stall 2 cycles, o_done in 3rd.
- LW addr 0x00002000, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> req high exactly 3 cycles, stall 4 cycles, o_done with o_load_data 0xDEADBEEF, o_load_op=`OP_LW, o_addr_lo 00.
- LH addr 0x00002001 -> o_addr_err pulse, o_mem_req never asserted, o_stall 0; SW 0x00002002 same result.
- SWL addr ...02, rt 0x11223344 -> be 0011, wdata[15:0] 0x1122; SWR addr ...01, rt 0x11223344 -> be 1100, wdata[31:16] 0x3344.
- TIMEOUT_CYCLES=8, LW never acked -> req high 8 cycles, o_bus_err pulse, no o_done, IDLE; a subsequent SW completes normally.
- Assert i_rst_n=0 mid-BUSY -> o_mem_req and o_stall fall asynchronously; after release, IDLE and all outputs 0.
